i2s_rx_deserializer: RTL and testbench
======================================

# i2s_rx_deserializer

Receives a standard (Philips, 1-bit delayed) I2S stream from an external ADC in slave mode. It recovers 32-bit left/right samples and presents them as one stereo pair on a valid/ready interface. The block sits at the capture end of the audio path, upstream of the DSP core. Its sample format and channel convention are the same as the I2S transmit stage that drives the DAC, so DSP output words can be fed straight back as transmit `audio_data`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: bits per channel word, MSB first.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `i2s_sck`, `i2s_ws` and `i2s_sd`. Minimum 2.

Ports:
- `clk`, input, 1: system clock. Must be at least 4× the SCK frequency.
- `reset`, input, 1: asynchronous, active-high.
- `i2s_sck`, input, 1: I2S bit clock from the ADC. Asynchronous to `clk`.
- `i2s_ws`, input, 1: word select. 0 = left, 1 = right.
- `i2s_sd`, input, 1: serial data.
- `m_left`, output, `DATA_WIDTH`: left sample of the presented pair.
- `m_right`, output, `DATA_WIDTH`: right sample of the presented pair.
- `m_valid`, output, 1: pair valid.
- `m_ready`, input, 1: downstream accepts the pair.
- `overrun`, output, 1: one-cycle pulse when a completed pair is dropped because of backpressure.
- `frame_err`, output, 1: one-cycle pulse when a word has the wrong bit count.

## Operation
- **Synchronization.** All three I2S inputs pass through `SYNC_STAGES` flip-flops.
- **Edge detection.** An SCK rising edge is detected as synchronized sck = 1 while the previous sampled sck = 0. All I2S activity happens only on detected rising edges.
- **Per-edge sampling.** On each rising edge the block samples `ws` and `sd`, shifts `sd` into a `DATA_WIDTH` shift register (MSB first), and increments the bit counter.
  - The bit counter is `$clog2(DATA_WIDTH)+1` bits and saturates at its maximum value.
  - The block also keeps `ws_q`, the WS value from the previous rising edge.
- **Word boundary.** A boundary is a rising edge where sampled `ws` != `ws_q`.
  - The `sd` bit sampled on that edge is the LSB of the word for channel `ws_q`.
  - The completed word is the shift register including this bit.
  - After the boundary the bit counter is set to 0, and the following edge carries the MSB of the new channel.
- **State machine.**
  - HUNT: the state after reset. Shifting runs, but nothing is captured. The first boundary moves the block to RECV and discards the partial word.
  - RECV: at each boundary the block checks the bit count, counting the boundary bit.
    - Count == `DATA_WIDTH`: the word is good.
    - Count != `DATA_WIDTH`: the block pulses `frame_err`, discards the word, clears `left_ok`, and stays in RECV.
- **Pair assembly.**
  - A good left word goes into `left_hold` and sets `left_ok`.
  - A good right word with `left_ok` = 1 completes a pair and clears `left_ok`.
  - A good right word with `left_ok` = 0 is discarded silently. There is no error.
- **Output handshake.**
  - When a pair completes and `m_valid` = 0, or `m_valid` = 1 and `m_ready` = 1 in the same cycle, `m_left`/`m_right` load the pair and `m_valid` is 1 on the next cycle.
  - When a pair completes while `m_valid` = 1 and `m_ready` = 0, the block pulses `overrun`, discards the new pair, and leaves the outputs unchanged.
  - A transfer occurs when `m_valid` and `m_ready` are both high. `m_valid` drops the next cycle unless a new pair loads in that same cycle.
  - While `m_valid` = 1, `m_left`/`m_right` are stable.
- **Width.** Words are raw two's-complement bit patterns. There is no sign extension or truncation.

## Timing
- **Reset values.** `m_left` = 0, `m_right` = 0, `m_valid` = 0, `overrun` = 0, `frame_err` = 0. The shift register, counter, `ws_q` and `left_ok` clear, synchronizers clear to 0, and the state is HUNT.
- **Latency.** From the pin-level SCK rising edge of the right-word LSB to `m_valid` high is `SYNC_STAGES`+2 clk cycles, ±1 cycle for synchronizer phase.
- **Pulse alignment.** `overrun` and `frame_err` are single-cycle pulses, in the same cycle `m_valid` would have loaded.
- **Reset mid-frame.** All partial data is dropped. The next pair is output only after one HUNT boundary, a full left word, and a full right word.
- **SCK stops.** State holds indefinitely. There is no timeout.

## Test plan
1. **Normal frame.** SCK = clk/8, frames of left 0xDEADBEEF / right 0x12345678, `m_ready` = 1. The first partial frame after reset is discarded. Each later frame produces exactly one `m_valid` pulse carrying those values.
2. **Backpressure.** `m_ready` = 0 across three frames with distinct values A, B, C. The outputs hold A. `overrun` pulses exactly twice. After `m_ready` = 1 the handshake completes with A, and the next output is frame D.
3. **Short word.** WS toggles after 31 bits in one left word. `frame_err` pulses once, that frame produces no output, and the next correct frame outputs normally.
4. **Accept/complete collision.** `m_ready` rises in the exact cycle a new pair completes. `m_valid` stays 1, the outputs switch to the new pair, and `overrun` = 0.
5. **Reset mid-frame.** Assert `reset` during bit 10 of a right word. All outputs go to 0 immediately. The first valid pair appears only after a HUNT boundary plus a full left and right word.
6. **Right-only start.** Release reset so that the first RECV word is a right word. That word is discarded silently with no `frame_err`, and the following left/right pair outputs correctly.

Source files
------------

// File: rtl/i2s_rx_deserializer.sv
// ---------------------------------------------------------------------------
// i2s_rx_deserializer
//   Philips I2S slave receiver. Oversamples SCK/WS/SD with the system clock,
//   recovers DATA_WIDTH-bit left/right words (MSB first, one-bit WS delay) and
//   presents complete stereo pairs on a valid/ready output.
//
// Ports
//   clk, reset           system clock, asynchronous active-high reset
//   i2s_sck/ws/sd        I2S pins from the ADC, asynchronous to clk
//   m_left, m_right      presented pair, stable while m_valid is high
//   m_valid, m_ready     output handshake
//   overrun              1-cycle pulse: completed pair dropped (backpressure)
//   frame_err            1-cycle pulse: word ended with the wrong bit count
// ---------------------------------------------------------------------------
module i2s_rx_deserializer #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i2s_sck,
   input  logic                  i2s_ws,
   input  logic                  i2s_sd,
   output logic [DATA_WIDTH-1:0] m_left,
   output logic [DATA_WIDTH-1:0] m_right,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  overrun,
   output logic                  frame_err
);

   localparam int CW = $clog2(DATA_WIDTH) + 1;

   localparam logic [0:0] ST_HUNT = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

   localparam logic [CW-1:0] CNT_MAX  = '1;
   // Counter value on the boundary edge of a full word (boundary bit not yet counted).
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

   logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
   logic                   sck_s, ws_s, sd_s, sck_prev;
   logic                   rise, boundary, in_recv, good, pair_done, load;
   logic [DATA_WIDTH-1:0]  shreg, word, left_hold;
   logic [CW-1:0]          bit_cnt;
   logic                   ws_q, left_ok;
   logic [0:0]             state;

   // Synchronizers; all three pins share the same depth so SD/WS stay aligned to SCK.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_sync <= '0;
         ws_sync  <= '0;
         sd_sync  <= '0;
         sck_prev <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck};
         ws_sync  <= {ws_sync[SYNC_STAGES-2:0],  i2s_ws};
         sd_sync  <= {sd_sync[SYNC_STAGES-2:0],  i2s_sd};
         sck_prev <= sck_s;
      end
   end

   assign sck_s = sck_sync[SYNC_STAGES-1];
   assign ws_s  = ws_sync[SYNC_STAGES-1];
   assign sd_s  = sd_sync[SYNC_STAGES-1];

   assign rise     = sck_s & ~sck_prev;
   // A WS change marks the LSB edge of the word for channel ws_q.
   assign boundary = rise & (ws_s != ws_q);
   assign in_recv  = (state == ST_RECV);
   assign word     = {shreg[DATA_WIDTH-2:0], sd_s};
   assign good     = (bit_cnt == CNT_LAST);

   // A right word that is good and follows a good left word completes a pair.
   assign pair_done = boundary & in_recv & good & ws_q & left_ok;
   assign load      = pair_done & (~m_valid | m_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         ws_q      <= 1'b0;
         left_ok   <= 1'b0;
         left_hold <= '0;
         state     <= ST_HUNT;
         m_left    <= '0;
         m_right   <= '0;
         m_valid   <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= pair_done & m_valid & ~m_ready;
         frame_err <= boundary & in_recv & ~good;

         if (rise) begin
            shreg <= word;
            ws_q  <= ws_s;
            if (boundary)
               bit_cnt <= '0;
            else if (bit_cnt != CNT_MAX)
               bit_cnt <= bit_cnt + 1'b1;
         end

         if (boundary) begin
            if (!in_recv) begin
               state <= ST_RECV;            // partial word from HUNT is dropped
            end else if (!good) begin
               left_ok <= 1'b0;
            end else if (!ws_q) begin
               left_hold <= word;
               left_ok   <= 1'b1;
            end else begin
               left_ok <= 1'b0;             // right word consumed (or orphan dropped)
            end
         end

         if (load) begin
            m_left  <= left_hold;
            m_right <= word;
            m_valid <= 1'b1;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx_deserializer
//   Drives I2S frames (SCK = clk/8) into i2s_rx_deserializer and checks the
//   recovered pairs, overrun and frame_err against a word-level model.
// ---------------------------------------------------------------------------
module tb_i2s_rx_deserializer;

   localparam int W     = 32;
   localparam int SS    = 2;
   localparam int CLK_P = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         i2s_sck, i2s_ws, i2s_sd;
   logic [W-1:0] m_left, m_right;
   logic         m_valid, m_ready, overrun, frame_err;

   always #(CLK_P/2) clk = ~clk;

   i2s_rx_deserializer #(.DATA_WIDTH(W), .SYNC_STAGES(SS)) dut (
      .clk       (clk),
      .reset     (reset),
      .i2s_sck   (i2s_sck),
      .i2s_ws    (i2s_ws),
      .i2s_sd    (i2s_sd),
      .m_left    (m_left),
      .m_right   (m_right),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- monitor (only writer of these) ----------------
   logic [2*W-1:0] got_q[$];
   int  n_ovr   = 0;
   int  n_ferr  = 0;
   int  n_vfall = 0;
   logic mv_prev = 1'b0;
   time t_valid = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (m_valid && m_ready) got_q.push_back({m_left, m_right});
         if (overrun)   n_ovr++;
         if (frame_err) n_ferr++;
         if (m_valid && !mv_prev) t_valid = $time;
         if (!m_valid && mv_prev) n_vfall++;
      end
      mv_prev = m_valid;
   end

   // ---------------- word-level reference model ----------------
   // Words arrive as (channel, bit count, value). The first word after reset
   // only ends the hunt; if it is a right word its first edge already is the
   // hunt boundary, so its remaining bits form a RECV word one bit short.
   bit             mdl_first;
   bit             mdl_left_ok;
   logic [W-1:0]   mdl_hold;
   logic [2*W-1:0] exp_q[$];
   int             exp_ferr = 0;
   time            t_rise = 0;

   task automatic judge(input logic ch, input int n, input logic [W-1:0] val);
      if (n != W) begin
         exp_ferr++;
         mdl_left_ok = 0;
      end else if (ch == 1'b0) begin
         mdl_hold    = val;
         mdl_left_ok = 1;
      end else begin
         if (mdl_left_ok) exp_q.push_back({mdl_hold, val});
         mdl_left_ok = 0;
      end
   endtask

   task automatic model_word(input logic ch, input int n, input logic [W-1:0] val);
      if (mdl_first) begin
         mdl_first = 0;
         if (ch == 1'b1) judge(ch, n - 1, val);
      end else begin
         judge(ch, n, val);
      end
   endtask

   // ---------------- stimulus ----------------
   // One SCK period = 8 clk: low 4, high 4. WS/SD change while SCK is low.
   // With collide set, m_ready is pulsed high for exactly the cycle in which
   // this edge's word boundary is processed.
   task automatic send_bit(input logic ws, input logic sd, input bit collide);
      @(posedge clk); #1;
      i2s_sck = 1'b0;
      i2s_ws  = ws;
      i2s_sd  = sd;
      repeat (4) @(posedge clk);
      #1;
      i2s_sck = 1'b1;
      t_rise  = $time;
      if (collide) begin
         @(posedge clk);
         @(posedge clk); #1;
         m_ready = 1'b1;
         @(posedge clk); #1;
         m_ready = 1'b0;
      end else begin
         repeat (3) @(posedge clk);
      end
   endtask

   // Philips framing: WS on the LSB already shows the next channel.
   task automatic send_word(input logic ch, input int n, input logic [W-1:0] val, input bit collide);
      for (int i = n - 1; i >= 0; i--)
         send_bit((i == 0) ? ~ch : ch, val[i], collide && (i == 0));
      model_word(ch, n, val);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      i2s_sck = 1'b0;
      i2s_ws  = 1'b0;
      i2s_sd  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset       = 1'b0;
      mdl_first   = 1;
      mdl_left_ok = 0;
   endtask

   // Reset, a partial left word (hunt) and an orphan right word.
   task automatic preamble();
      do_reset();
      send_word(1'b0, $urandom_range(2, 31), $urandom, 0);
      send_word(1'b1, W, $urandom, 0);
   endtask

   task automatic drain();
      repeat (6) @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; i2s_sck = 1'b0; i2s_ws = 1'b0; i2s_sd = 1'b0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (m_left !== '0)     begin errors++; $display("FAIL reset_m_left got=%h exp=0", m_left); end
      checks++; if (m_right !== '0)    begin errors++; $display("FAIL reset_m_right got=%h exp=0", m_right); end
      checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
      checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
   endtask

   task automatic test_normal();
      int g0, o0, f0, e0, lat;
      do_reset();
      m_ready = 1'b1;
      exp_q.delete();
      g0 = got_q.size(); o0 = n_ovr; f0 = n_ferr; e0 = exp_ferr;
      send_word(1'b0, 20, 32'hDEADBEEF, 0);
      send_word(1'b1, W, 32'h12345678, 0);
      for (int k = 0; k < 3; k++) begin
         send_word(1'b0, W, 32'hDEADBEEF, 0);
         send_word(1'b1, W, 32'h12345678, 0);
         drain();
         if (k == 0) begin
            lat = int'((t_valid - t_rise) / CLK_P);
            checks++;
            if (t_valid < t_rise || lat < SS + 1 || lat > SS + 3) begin
               errors++; $display("FAIL normal_latency got=%0d cycles exp=%0d..%0d", lat, SS + 1, SS + 3);
            end
         end
      end
      checks++;
      if (got_q.size() - g0 != 3) begin
         errors++; $display("FAIL normal_count got=%0d exp=3", got_q.size() - g0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q[g0 + i] !== {32'hDEADBEEF, 32'h12345678} || got_q[g0 + i] !== exp_q[i]) begin
               errors++; $display("FAIL normal_pair%0d got=%h exp=deadbeef12345678", i, got_q[g0 + i]);
            end
         end
      end
      checks++; if (n_ovr != o0) begin errors++; $display("FAIL normal_overrun got=%0d exp=0", n_ovr - o0); end
      checks++; if (n_ferr - f0 != exp_ferr - e0) begin errors++; $display("FAIL normal_frame_err got=%0d exp=%0d", n_ferr - f0, exp_ferr - e0); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] vl[4], vr[4];
      int g0, o0;
      for (int i = 0; i < 4; i++) begin vl[i] = $urandom; vr[i] = $urandom; end
      m_ready = 1'b0;
      preamble();
      g0 = got_q.size(); o0 = n_ovr;
      for (int i = 0; i < 3; i++) begin
         send_word(1'b0, W, vl[i], 0);
         send_word(1'b1, W, vr[i], 0);
      end
      drain();
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held got=%b exp=1", m_valid); end
      checks++; if ({m_left, m_right} !== {vl[0], vr[0]}) begin errors++; $display("FAIL bp_hold_A got=%h%h exp=%h%h", m_left, m_right, vl[0], vr[0]); end
      checks++; if (n_ovr - o0 != 2) begin errors++; $display("FAIL bp_overrun_count got=%0d exp=2", n_ovr - o0); end
      @(posedge clk); #1;
      m_ready = 1'b1;
      drain();
      send_word(1'b0, W, vl[3], 0);
      send_word(1'b1, W, vr[3], 0);
      drain();
      checks++;
      if (got_q.size() - g0 != 2) begin
         errors++; $display("FAIL bp_count got=%0d exp=2", got_q.size() - g0);
      end else begin
         checks++; if (got_q[g0] !== {vl[0], vr[0]}) begin errors++; $display("FAIL bp_first_A got=%h exp=%h%h", got_q[g0], vl[0], vr[0]); end
         checks++; if (got_q[g0 + 1] !== {vl[3], vr[3]}) begin errors++; $display("FAIL bp_next_D got=%h exp=%h%h", got_q[g0 + 1], vl[3], vr[3]); end
      end
   endtask

   task automatic test_short_word();
      int g0, f0, e0;
      m_ready = 1'b1;
      preamble();
      exp_q.delete();
      g0 = got_q.size(); f0 = n_ferr; e0 = exp_ferr;
      send_word(1'b0, W, $urandom, 0);
      send_word(1'b1, W, $urandom, 0);
      send_word(1'b0, W - 1, $urandom, 0);
      send_word(1'b1, W, $urandom, 0);
      send_word(1'b0, W, $urandom, 0);
      send_word(1'b1, W, $urandom, 0);
      drain();
      checks++; if (n_ferr - f0 != 1 || exp_ferr - e0 != 1) begin errors++; $display("FAIL short_frame_err got=%0d exp=1", n_ferr - f0); end
      checks++;
      if (got_q.size() - g0 != 2 || exp_q.size() != 2) begin
         errors++; $display("FAIL short_count got=%0d exp=2", got_q.size() - g0);
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_q[g0 + i] !== exp_q[i]) begin errors++; $display("FAIL short_pair%0d got=%h exp=%h", i, got_q[g0 + i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_collision();
      logic [W-1:0] al, ar, bl, br;
      int g0, o0, v0;
      al = $urandom; ar = $urandom; bl = $urandom; br = $urandom;
      m_ready = 1'b0;
      preamble();
      g0 = got_q.size(); o0 = n_ovr;
      send_word(1'b0, W, al, 0);
      send_word(1'b1, W, ar, 0);
      drain();
      v0 = n_vfall;
      send_word(1'b0, W, bl, 0);
      send_word(1'b1, W, br, 1);
      drain();
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL coll_valid got=%b exp=1", m_valid); end
      checks++; if (n_vfall != v0) begin errors++; $display("FAIL coll_valid_gap got=%0d drops exp=0", n_vfall - v0); end
      checks++; if ({m_left, m_right} !== {bl, br}) begin errors++; $display("FAIL coll_new_pair got=%h%h exp=%h%h", m_left, m_right, bl, br); end
      checks++; if (n_ovr != o0) begin errors++; $display("FAIL coll_overrun got=%0d exp=0", n_ovr - o0); end
      checks++;
      if (got_q.size() - g0 != 1 || got_q[got_q.size() - 1] !== {al, ar}) begin
         errors++; $display("FAIL coll_accept_A got=%0d transfers exp=1 of %h%h", got_q.size() - g0, al, ar);
      end
      m_ready = 1'b1;
      drain();
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] rv;
      int g0, f0, e0;
      m_ready = 1'b0;
      preamble();
      send_word(1'b0, W, $urandom, 0);
      send_word(1'b1, W, $urandom, 0);
      send_word(1'b0, W, $urandom, 0);
      rv = $urandom;
      for (int i = W - 1; i > W - 11; i--) send_bit(1'b1, rv[i], 0);
      reset = 1'b1;
      #1;
      checks++;
      if (m_valid !== 1'b0 || m_left !== '0 || m_right !== '0) begin
         errors++; $display("FAIL midreset_outputs got=v%b %h %h exp=v0 0 0", m_valid, m_left, m_right);
      end
      do_reset();
      m_ready = 1'b1;
      exp_q.delete();
      g0 = got_q.size(); f0 = n_ferr; e0 = exp_ferr;
      send_word(1'b1, W - 10, rv, 0);
      send_word(1'b0, W, $urandom, 0);
      send_word(1'b1, W, $urandom, 0);
      drain();
      checks++;
      if (got_q.size() - g0 != 1 || exp_q.size() != 1 || got_q[g0] !== exp_q[0]) begin
         errors++; $display("FAIL midreset_first_pair got=%0d transfers exp=1", got_q.size() - g0);
      end
      checks++; if (n_ferr - f0 != exp_ferr - e0) begin errors++; $display("FAIL midreset_frame_err got=%0d exp=%0d", n_ferr - f0, exp_ferr - e0); end
   endtask

   task automatic test_right_only();
      logic [W-1:0] l1, r1;
      int g0, f0;
      l1 = $urandom; r1 = $urandom;
      m_ready = 1'b1;
      do_reset();
      g0 = got_q.size(); f0 = n_ferr;
      send_word(1'b0, 13, $urandom, 0);
      send_word(1'b1, W, $urandom, 0);
      send_word(1'b0, W, l1, 0);
      send_word(1'b1, W, r1, 0);
      drain();
      checks++; if (n_ferr != f0) begin errors++; $display("FAIL rightonly_frame_err got=%0d exp=0", n_ferr - f0); end
      checks++;
      if (got_q.size() - g0 != 1 || got_q[got_q.size() - 1] !== {l1, r1}) begin
         errors++; $display("FAIL rightonly_pair got=%0d transfers exp=1 of %h%h", got_q.size() - g0, l1, r1);
      end
   endtask

   task automatic test_random();
      int g0, f0, e0, nl, nr;
      m_ready = 1'b1;
      do_reset();
      exp_q.delete();
      g0 = got_q.size(); f0 = n_ferr; e0 = exp_ferr;
      send_word(1'b0, $urandom_range(2, 31), $urandom, 0);
      for (int k = 0; k < 10; k++) begin
         nl = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 36) : W;
         nr = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 36) : W;
         send_word(1'b1, nr, $urandom, 0);
         send_word(1'b0, nl, $urandom, 0);
      end
      send_word(1'b1, W, $urandom, 0);
      drain();
      checks++; if (n_ferr - f0 != exp_ferr - e0) begin errors++; $display("FAIL rand_frame_err got=%0d exp=%0d", n_ferr - f0, exp_ferr - e0); end
      checks++;
      if (got_q.size() - g0 != exp_q.size()) begin
         errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[g0 + i] !== exp_q[i]) begin errors++; $display("FAIL rand_pair%0d got=%h exp=%h", i, got_q[g0 + i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_backpressure();
      test_short_word();
      test_collision();
      test_reset_mid();
      test_right_only();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
